// File: rtl/clkdiv_pkg.sv
//------------------------------------------------------------------------------
// clkdiv_pkg : state encoding and mode constants for clock_enable_divider
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

package clkdiv_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      HOLD = 2'd2
   } clkdiv_state_t;

   localparam logic MODE_FREE    = 1'b0;
   localparam logic MODE_ONESHOT = 1'b1;

endpackage

`default_nettype wire

// File: rtl/clock_enable_divider.sv
//------------------------------------------------------------------------------
// clock_enable_divider : programmable tick-enable generator with one-shot mode
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module clock_enable_divider
   import clkdiv_pkg::*;
#(
   parameter int          WIDTH       = 28,
   parameter int unsigned DEFAULT_DIV = 4
) (
   input  logic             clk,
   input  logic             RESET,
   input  logic             en,
   input  logic             oneshot,
   input  logic             div_ld,
   input  logic [WIDTH-1:0] div_val,
   output logic             tick,
   output logic             sq_out,
   output logic [WIDTH-1:0] cnt,
   output logic             busy
);

   localparam logic [WIDTH-1:0] c_DIV_RST =
      (DEFAULT_DIV == 0) ? WIDTH'(1) : WIDTH'(DEFAULT_DIV);

   clkdiv_state_t    r_state;
   logic [WIDTH-1:0] r_cnt;
   logic [WIDTH-1:0] r_div;
   logic [WIDTH-1:0] r_shadow;
   logic             r_pend;
   logic             r_os;
   logic             r_tick;
   logic             r_sq;

   logic [WIDTH-1:0] w_div_sane;
   logic [WIDTH-1:0] w_div_m1;
   logic             w_wrap;

   // r_div is never zero, so the subtraction below cannot underflow
   assign w_div_sane = (div_val == '0) ? WIDTH'(1) : div_val;
   assign w_div_m1   = r_div - WIDTH'(1);
   assign w_wrap     = (r_cnt == w_div_m1);

   always_ff @(posedge clk) begin
      if (RESET) begin
         r_state  <= IDLE;
         r_cnt    <= '0;
         r_div    <= c_DIV_RST;
         r_shadow <= c_DIV_RST;
         r_pend   <= 1'b0;
         r_os     <= MODE_FREE;
         r_tick   <= 1'b0;
         r_sq     <= 1'b0;
      end else begin
         r_tick <= 1'b0;
         case (r_state)
            IDLE: begin
               r_cnt <= '0;
               r_sq  <= 1'b0;
               r_os  <= oneshot;
               if (div_ld) r_div <= w_div_sane;
               if (en) r_state <= RUN;
            end
            RUN: begin
               if (!en) begin
                  r_state <= IDLE;
                  r_cnt   <= '0;
                  r_sq    <= 1'b0;
                  r_pend  <= 1'b0;
                  if (div_ld)      r_div <= w_div_sane;
                  else if (r_pend) r_div <= r_shadow;
               end else if (w_wrap) begin
                  r_cnt  <= '0;
                  r_tick <= 1'b1;
                  r_sq   <= ~r_sq;
                  r_pend <= 1'b0;
                  // a load landing on the wrap edge takes priority over the shadow
                  if (div_ld)      r_div <= w_div_sane;
                  else if (r_pend) r_div <= r_shadow;
                  if (r_os == MODE_ONESHOT) r_state <= HOLD;
               end else begin
                  r_cnt <= r_cnt + WIDTH'(1);
                  if (div_ld) begin
                     r_shadow <= w_div_sane;
                     r_pend   <= 1'b1;
                  end
               end
            end
            HOLD: begin
               r_cnt <= '0;
               if (div_ld) r_div <= w_div_sane;
               if (!en) begin
                  r_state <= IDLE;
                  r_sq    <= 1'b0;
               end
            end
            default: begin
               r_state <= IDLE;
               r_cnt   <= '0;
            end
         endcase
      end
   end

   assign tick   = r_tick;
   assign sq_out = r_sq;
   assign cnt    = r_cnt;
   assign busy   = (r_state == RUN);

endmodule

`default_nettype wire

// File: tb/tb_clock_enable_divider.sv
//------------------------------------------------------------------------------
// tb_clock_enable_divider : directed self-checking bench for clock_enable_divider
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_clock_enable_divider;

   logic        clk = 1'b0;
   logic        RESET;
   logic        en, oneshot, div_ld;
   logic [27:0] div_val;
   logic        tick, sq_out, busy;
   logic [27:0] cnt;

   logic        en4, div_ld4;
   logic [3:0]  div_val4;
   logic        tick4, sq4, busy4;
   logic [3:0]  cnt4;

   int n_chk  = 0;
   int n_pass = 0;

   always #5 clk = ~clk;

   clock_enable_divider #(.WIDTH(28), .DEFAULT_DIV(4)) dut (
      .clk(clk), .RESET(RESET), .en(en), .oneshot(oneshot),
      .div_ld(div_ld), .div_val(div_val),
      .tick(tick), .sq_out(sq_out), .cnt(cnt), .busy(busy)
   );

   clock_enable_divider #(.WIDTH(4), .DEFAULT_DIV(4)) dut4 (
      .clk(clk), .RESET(RESET), .en(en4), .oneshot(1'b0),
      .div_ld(div_ld4), .div_val(div_val4),
      .tick(tick4), .sq_out(sq4), .cnt(cnt4), .busy(busy4)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp)
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      else
         n_pass++;
   endtask

   task automatic cyc(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   initial begin
      int ticks, first, second, cmax;

      RESET = 1'b1; en = 1'b0; oneshot = 1'b0; div_ld = 1'b0; div_val = '0;
      en4 = 1'b0; div_ld4 = 1'b0; div_val4 = '0;
      cyc(2);
      RESET = 1'b0;
      chk("rst_tick", tick, 0);
      chk("rst_sq",   sq_out, 0);
      chk("rst_cnt",  cnt, 0);
      chk("rst_busy", busy, 0);

      // reset in the middle of a div=8 run
      div_ld = 1'b1; div_val = 28'd8;
      cyc(1);
      div_ld = 1'b0; en = 1'b1;
      cyc(4);
      chk("t1_pre_cnt", cnt, 3);
      RESET = 1'b1;
      cyc(1);
      RESET = 1'b0;
      chk("t1_cnt",  cnt, 0);
      chk("t1_tick", tick, 0);
      chk("t1_sq",   sq_out, 0);
      chk("t1_busy", busy, 0);

      // free run, divisor back to default 4; k=0 is the IDLE->RUN edge
      for (int k = 0; k <= 8; k++) begin
         cyc(1);
         chk($sformatf("t2_cnt_%0d", k),  cnt, k % 4);
         chk($sformatf("t2_tick_%0d", k), tick, (k > 0 && k % 4 == 0) ? 1 : 0);
         chk($sformatf("t2_sq_%0d", k),   sq_out, (k / 4) % 2);
      end
      chk("t2_busy", busy, 1);

      // drop en mid-period while sq_out is high
      cyc(6);
      chk("t5_pre_cnt", cnt, 2);
      chk("t5_pre_sq",  sq_out, 1);
      en = 1'b0;
      cyc(1);
      chk("t5_cnt",  cnt, 0);
      chk("t5_tick", tick, 0);
      chk("t5_busy", busy, 0);
      chk("t5_sq",   sq_out, 0);
      en = 1'b1;
      cyc(1);
      chk("t5_re_busy", busy, 1);
      cyc(3);
      chk("t5_re_cnt3", cnt, 3);
      chk("t5_re_notick", tick, 0);
      cyc(1);
      chk("t5_re_tick", tick, 1);
      chk("t5_re_cnt0", cnt, 0);
      en = 1'b0;
      cyc(2);

      // one-shot, div=5
      oneshot = 1'b1; div_ld = 1'b1; div_val = 28'd5;
      cyc(1);
      div_ld = 1'b0; en = 1'b1;
      ticks = 0; first = -1;
      for (int i = 0; i < 20; i++) begin
         cyc(1);
         if (tick) begin
            ticks++;
            if (first < 0) first = i;
         end
      end
      chk("t3_ticks", ticks, 1);
      chk("t3_pos",   first, 5);
      chk("t3_busy",  busy, 0);
      chk("t3_cnt",   cnt, 0);
      chk("t3_sq_held", sq_out, 1);
      en = 1'b0;
      cyc(1);
      en = 1'b1;
      ticks = 0; first = -1;
      for (int i = 0; i < 10; i++) begin
         cyc(1);
         if (tick) begin
            ticks++;
            if (first < 0) first = i;
         end
      end
      chk("t3b_ticks", ticks, 1);
      chk("t3b_pos",   first, 5);
      en = 1'b0; oneshot = 1'b0;
      cyc(2);

      // divisor reload while running
      div_ld = 1'b1; div_val = 28'd6;
      cyc(1);
      div_ld = 1'b0; en = 1'b1;
      cyc(3);
      chk("t4_cnt2", cnt, 2);
      div_ld = 1'b1; div_val = 28'd3;
      cyc(1);
      div_ld = 1'b0;
      chk("t4_cnt3", cnt, 3);
      cyc(2);
      chk("t4_cnt5", cnt, 5);
      chk("t4_no_trunc", tick, 0);
      cyc(1);
      chk("t4_tick_a", tick, 1);
      cyc(2);
      chk("t4_gap", tick, 0);
      chk("t4_gap_cnt", cnt, 2);
      cyc(1);
      chk("t4_tick_b", tick, 1);
      cyc(3);
      chk("t4_tick_c", tick, 1);
      div_ld = 1'b1; div_val = 28'd0;
      cyc(1);
      div_ld = 1'b0;
      chk("t4_z_cnt1", cnt, 1);
      cyc(1);
      chk("t4_z_notick", tick, 0);
      cyc(1);
      chk("t4_z_tick0", tick, 1);
      cyc(1);
      chk("t4_z_tick1", tick, 1);
      chk("t4_z_cnt", cnt, 0);
      // load on the wrap edge applies to the very next period
      div_ld = 1'b1; div_val = 28'd2;
      cyc(1);
      div_ld = 1'b0;
      chk("t4_w_tick", tick, 1);
      cyc(1);
      chk("t4_w_gap", tick, 0);
      chk("t4_w_cnt", cnt, 1);
      cyc(1);
      chk("t4_w_tick2", tick, 1);
      en = 1'b0;
      cyc(2);

      // narrow instance, maximum divisor
      div_ld4 = 1'b1; div_val4 = 4'd15;
      cyc(1);
      div_ld4 = 1'b0; en4 = 1'b1;
      cyc(1);
      ticks = 0; first = -1; second = -1; cmax = 0;
      for (int i = 1; i <= 31; i++) begin
         cyc(1);
         if (int'(cnt4) > cmax) cmax = int'(cnt4);
         if (tick4) begin
            ticks++;
            if (first < 0) first = i;
            else if (second < 0) second = i;
         end
      end
      chk("t6_ticks",  ticks, 2);
      chk("t6_first",  first, 15);
      chk("t6_second", second, 30);
      chk("t6_cmax",   cmax, 14);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

`default_nettype wire
